// File: rtl/mac_sequencer_if.sv
`default_nettype none
// ============================================================================
//  mac_sequencer_if : start/result handshakes plus operand-RAM and MAC buses
//  for one mac_sequencer. Optional MAC_SEQ_BIAS_EN adds the bias field.
//  Revision : 1.0
// ============================================================================
interface mac_sequencer_if #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 8
);
   logic                     start_valid;
   logic                     start_ready;
   logic [ADDR_W:0]          len;
   logic [ADDR_W-1:0]        a_base;
   logic [ADDR_W-1:0]        b_base;
`ifdef MAC_SEQ_BIAS_EN
   logic signed [WIDTH-1:0]  bias;
`endif
   logic                     rd_en;
   logic [ADDR_W-1:0]        a_addr;
   logic [ADDR_W-1:0]        b_addr;
   logic [WIDTH-1:0]         a_rdata;
   logic [WIDTH-1:0]         b_rdata;
   logic                     mac_clr;
   logic                     mac_en;
   logic [WIDTH-1:0]         mac_a;
   logic [WIDTH-1:0]         mac_b;
   logic [WIDTH-1:0]         mac_out;
   logic                     result_valid;
   logic                     result_ready;
   logic [WIDTH-1:0]         result;
   logic                     len_err;

   // master = the sequencer; slave = scheduler, RAMs and MAC around it
   modport master (
`ifdef MAC_SEQ_BIAS_EN
      input  bias,
`endif
      input  start_valid, len, a_base, b_base,
      output start_ready,
      output rd_en, a_addr, b_addr,
      input  a_rdata, b_rdata,
      output mac_clr, mac_en, mac_a, mac_b,
      input  mac_out,
      output result_valid, result, len_err,
      input  result_ready
   );

   modport slave (
`ifdef MAC_SEQ_BIAS_EN
      output bias,
`endif
      output start_valid, len, a_base, b_base,
      input  start_ready,
      input  rd_en, a_addr, b_addr,
      output a_rdata, b_rdata,
      input  mac_clr, mac_en, mac_a, mac_b,
      output mac_out,
      input  result_valid, result, len_err,
      output result_ready
   );
endinterface
`default_nettype wire

// File: rtl/mac_sequencer.sv
`default_nettype none
// ============================================================================
//  mac_sequencer : drives one MAC and its two operand RAMs through a single
//  dot-product job. Optional MAC_SEQ_BIAS_EN adds a bias preload state.
//  Revision : 1.0
// ============================================================================
module mac_sequencer #(
   parameter int WIDTH   = 8,
   parameter int ADDR_W  = 8,
   parameter int MAX_LEN = 3
) (
   input wire              clk,
   input wire              reset,
   mac_sequencer_if.master bus
);
   localparam int LEN_W = ADDR_W + 1;
`ifdef MAC_SEQ_BIAS_EN
   // The bias enable consumes one of the MAC's accumulation slots.
   localparam logic [LEN_W-1:0] LEN_LIMIT = LEN_W'(MAX_LEN - 1);
`else
   localparam logic [LEN_W-1:0] LEN_LIMIT = LEN_W'(MAX_LEN);
`endif

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
`ifdef MAC_SEQ_BIAS_EN
      S_BIAS    = 3'd2,
`endif
      S_ISSUE   = 3'd3,
      S_DRAIN   = 3'd4,
      S_FLUSH   = 3'd5,
      S_CAPTURE = 3'd6,
      S_DONE    = 3'd7
   } state_t;

   state_t             state_q,    state_d;
   logic [LEN_W-1:0]   k_q,        k_d;
   logic [LEN_W-1:0]   len_q,      len_d;
   logic [ADDR_W-1:0]  a_base_q,   a_base_d;
   logic [ADDR_W-1:0]  b_base_q,   b_base_d;
   logic               vq_q,       vq_d;
   logic               mac_clr_q,  mac_clr_d;
   logic [WIDTH-1:0]   result_q,   result_d;
   logic               len_err_q,  len_err_d;
`ifdef MAC_SEQ_BIAS_EN
   logic [WIDTH-1:0]   bias_q,     bias_d;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         k_q       <= '0;
         len_q     <= '0;
         a_base_q  <= '0;
         b_base_q  <= '0;
         vq_q      <= 1'b0;
         mac_clr_q <= 1'b0;
         result_q  <= '0;
         len_err_q <= 1'b0;
`ifdef MAC_SEQ_BIAS_EN
         bias_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         len_q     <= len_d;
         a_base_q  <= a_base_d;
         b_base_q  <= b_base_d;
         vq_q      <= vq_d;
         mac_clr_q <= mac_clr_d;
         result_q  <= result_d;
         len_err_q <= len_err_d;
`ifdef MAC_SEQ_BIAS_EN
         bias_q    <= bias_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      len_d     = len_q;
      a_base_d  = a_base_q;
      b_base_d  = b_base_q;
      mac_clr_d = 1'b0;
      result_d  = result_q;
      len_err_d = len_err_q;
      vq_d      = (state_q == S_ISSUE);
`ifdef MAC_SEQ_BIAS_EN
      bias_d    = bias_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start_valid) begin
               if (bus.len > LEN_LIMIT) begin
                  result_d  = '0;
                  len_err_d = 1'b1;
                  state_d   = S_DONE;
               end else begin
                  len_d     = bus.len;
                  a_base_d  = bus.a_base;
                  b_base_d  = bus.b_base;
                  k_d       = '0;
                  mac_clr_d = 1'b1;
`ifdef MAC_SEQ_BIAS_EN
                  bias_d    = bus.bias;
`endif
                  state_d   = S_CLEAR;
               end
            end
         end
         S_CLEAR: begin
`ifdef MAC_SEQ_BIAS_EN
            state_d = S_BIAS;
`else
            state_d = (len_q == '0) ? S_FLUSH : S_ISSUE;
`endif
         end
`ifdef MAC_SEQ_BIAS_EN
         S_BIAS: begin
            state_d = (len_q == '0) ? S_FLUSH : S_ISSUE;
         end
`endif
         S_ISSUE: begin
            k_d = k_q + 1'b1;
            if (k_d == len_q) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN:   state_d = S_FLUSH;
         // The flush enable pushes the completed sum through the quantizer.
         S_FLUSH:   state_d = S_CAPTURE;
         S_CAPTURE: begin
            result_d  = bus.mac_out;
            len_err_d = 1'b0;
            state_d   = S_DONE;
         end
         S_DONE: begin
            if (bus.result_ready) begin
               state_d = S_IDLE;
            end
         end
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.start_ready  = (state_q == S_IDLE);
      bus.rd_en        = (state_q == S_ISSUE);
      bus.a_addr       = '0;
      bus.b_addr       = '0;
      if (state_q == S_ISSUE) begin
         bus.a_addr = a_base_q + k_q[ADDR_W-1:0];
         bus.b_addr = b_base_q + k_q[ADDR_W-1:0];
      end
      bus.mac_clr      = mac_clr_q;
      bus.mac_en       = vq_q | (state_q == S_FLUSH);
      bus.mac_a        = '0;
      bus.mac_b        = '0;
      if (vq_q) begin
         bus.mac_a = bus.a_rdata;
         bus.mac_b = bus.b_rdata;
      end
`ifdef MAC_SEQ_BIAS_EN
      if (state_q == S_BIAS) begin
         bus.mac_en = 1'b1;
         bus.mac_a  = bias_q;
         bus.mac_b  = WIDTH'(1);
      end
`endif
      bus.result_valid = (state_q == S_DONE);
      bus.result       = result_q;
      bus.len_err      = len_err_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  tb_mac_sequencer : directed vector table plus reset / back-pressure
//  sequences, with a behavioural MAC and operand RAMs around the DUT.
//  Revision : 1.0
// ============================================================================
module tb_mac_sequencer;
   localparam int WIDTH  = 8;
   localparam int ADDR_W = 8;
`ifdef MAC_SEQ_BIAS_EN
   localparam int MAX_LEN  = 4;
   localparam int BIAS_VAL = -7;
   localparam int EXTRA    = 1;
`else
   localparam int MAX_LEN  = 3;
   localparam int BIAS_VAL = 0;
   localparam int EXTRA    = 0;
`endif
   localparam int NVEC = 9;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mac_sequencer_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

   mac_sequencer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int t0       = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int sat(input int v);
      int hi;
      int lo;
      hi = (1 << (WIDTH - 1)) - 1;
      lo = -(1 << (WIDTH - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // Behavioural MAC: saturating quantizer, output lags the sum by one enable.
   int               mac_sum;
   logic [WIDTH-1:0] mac_out_r;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mac_sum   <= 0;
         mac_out_r <= '0;
      end else if (bus.mac_clr) begin
         mac_sum   <= 0;
         mac_out_r <= '0;
      end else if (bus.mac_en) begin
         mac_sum   <= mac_sum + int'($signed(bus.mac_a)) * int'($signed(bus.mac_b));
         mac_out_r <= WIDTH'(sat(mac_sum));
      end
   end
   assign bus.mac_out = mac_out_r;

   logic [WIDTH-1:0] a_mem [0:255];
   logic [WIDTH-1:0] b_mem [0:255];
   always @(posedge clk) begin
      if (bus.rd_en) begin
         bus.a_rdata <= a_mem[bus.a_addr];
         bus.b_rdata <= b_mem[bus.b_addr];
      end
   end

   bit mon_en = 1'b0;
   int rd_cnt, en_cnt, clr_cnt, clr_cyc;
   int a_log [16];
   int b_log [16];
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.rd_en) begin
            if (rd_cnt < 16) begin
               a_log[rd_cnt] = int'(bus.a_addr);
               b_log[rd_cnt] = int'(bus.b_addr);
            end
            rd_cnt++;
         end
         if (bus.mac_en) en_cnt++;
         if (bus.mac_clr) begin
            clr_cnt++;
            clr_cyc = cyc - t0;
         end
      end
   end

   typedef struct {
      int len;
      int a_base;
      int b_base;
      int sum;
      int lat;
      bit err;
   } vec_t;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic mon_start();
      rd_cnt  = 0;
      en_cnt  = 0;
      clr_cnt = 0;
      clr_cyc = -1;
      mon_en  = 1'b1;
      t0      = cyc;
   endtask

   task automatic drive_start(input int i);
      bus.start_valid = 1'b1;
      bus.len         = (ADDR_W+1)'(vecs[i].len);
      bus.a_base      = ADDR_W'(vecs[i].a_base);
      bus.b_base      = ADDR_W'(vecs[i].b_base);
`ifdef MAC_SEQ_BIAS_EN
      bus.bias        = WIDTH'(BIAS_VAL);
`endif
   endtask

   task automatic wait_valid(output bit seen, output int lat);
      seen = 1'b0;
      lat  = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.result_valid) begin
            seen = 1'b1;
            lat  = cyc - t0;
            break;
         end
      end
   endtask

   task automatic run_job(input int i, input string tag);
      bit seen;
      int lat, exp_res, exp_lat;
      exp_res = vecs[i].err ? 0 : sat(vecs[i].sum + BIAS_VAL);
      exp_lat = vecs[i].err ? 1 : vecs[i].lat + EXTRA;
      @(posedge clk); #1;
      mon_start();
      drive_start(i);
      @(posedge clk); #1;
      bus.start_valid = 1'b0;
      wait_valid(seen, lat);
      chk($sformatf("%s result_valid seen", tag), int'(seen), 1);
      chk($sformatf("%s latency", tag), lat, exp_lat);
      chk($sformatf("%s result", tag), int'($signed(bus.result)), exp_res);
      chk($sformatf("%s len_err", tag), int'(bus.len_err), int'(vecs[i].err));
      chk($sformatf("%s rd_en count", tag), rd_cnt, vecs[i].err ? 0 : vecs[i].len);
      chk($sformatf("%s mac_en count", tag), en_cnt, vecs[i].err ? 0 : vecs[i].len + 1 + EXTRA);
      chk($sformatf("%s mac_clr count", tag), clr_cnt, vecs[i].err ? 0 : 1);
      if (!vecs[i].err) begin
         chk($sformatf("%s mac_clr cycle", tag), clr_cyc, 1);
         for (int j = 0; j < vecs[i].len && j < 16; j++) begin
            chk($sformatf("%s a_addr[%0d]", tag, j), a_log[j], (vecs[i].a_base + j) % 256);
            chk($sformatf("%s b_addr[%0d]", tag, j), b_log[j], (vecs[i].b_base + j) % 256);
         end
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("%s start_ready after accept", tag), int'(bus.start_ready), 1);
      chk($sformatf("%s result_valid after accept", tag), int'(bus.result_valid), 0);
      mon_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit seen;
      int lat, stable, exp3;

      bus.start_valid  = 1'b0;
      bus.len          = '0;
      bus.a_base       = '0;
      bus.b_base       = '0;
      bus.result_ready = 1'b1;
`ifdef MAC_SEQ_BIAS_EN
      bus.bias         = '0;
`endif
      for (int m = 0; m < 256; m++) begin
         a_mem[m] = '0;
         b_mem[m] = '0;
      end
      a_mem[0]   = 8'sd2;   a_mem[1]   = 8'sd3;   a_mem[2]   = -8'sd4;
      b_mem[0]   = 8'sd5;   b_mem[1]   = 8'sd1;   b_mem[2]   = 8'sd2;
      a_mem[254] = 8'sd7;   a_mem[255] = -8'sd1;
      b_mem[10]  = 8'sd3;   b_mem[11]  = 8'sd4;   b_mem[12]  = -8'sd5;
      a_mem[20]  = 8'sd100; a_mem[21]  = 8'sd100;
      b_mem[20]  = 8'sd100; b_mem[21]  = 8'sd100;

      //            len  a    b   sum  lat err   (lat/sum before bias)
      vecs[0] = '{  3,   0,   0,   5,   8, 1'b0};
      vecs[1] = '{  0,   0,   0,   0,   4, 1'b0};
      vecs[2] = '{  4,   0,   0,   0,   1, 1'b1};
      vecs[3] = '{  3, 254,  10,   7,   8, 1'b0};
      vecs[4] = '{  2,   0,   0,  13,   7, 1'b0};
      vecs[5] = '{  1,   1,   1,   3,   6, 1'b0};
      vecs[6] = '{  2,  20,  20, 20000, 7, 1'b0};
      vecs[7] = '{511,   0,   0,   0,   1, 1'b1};
      vecs[8] = '{  1, 255,  12,   5,   6, 1'b0};

      @(negedge clk);
      @(negedge clk);
      chk("reset start_ready", int'(bus.start_ready), 1);
      chk("reset result_valid", int'(bus.result_valid), 0);
      chk("reset rd_en", int'(bus.rd_en), 0);
      chk("reset mac_en", int'(bus.mac_en), 0);
      chk("reset mac_clr", int'(bus.mac_clr), 0);
      chk("reset result", int'(bus.result), 0);
      chk("reset len_err", int'(bus.len_err), 0);
      chk("reset a_addr", int'(bus.a_addr), 0);
      @(posedge clk); #1;
      reset = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         run_job(i, $sformatf("v%0d", i));
      end

      // Reset during ISSUE, then rerun the same job from scratch.
      @(posedge clk); #1;
      drive_start(0);
      @(posedge clk); #1;
      bus.start_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("pre-reset rd_en in ISSUE", int'(bus.rd_en), 1);
      #1 reset = 1'b1;
      #1;
      chk("async reset start_ready", int'(bus.start_ready), 1);
      chk("async reset rd_en", int'(bus.rd_en), 0);
      chk("async reset mac_en", int'(bus.mac_en), 0);
      chk("async reset result_valid", int'(bus.result_valid), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      run_job(0, "restart");

      // Busy-time start is ignored; result held while result_ready is low.
      exp3 = sat(vecs[3].sum + BIAS_VAL);
      bus.result_ready = 1'b0;
      @(posedge clk); #1;
      mon_start();
      drive_start(3);
      @(posedge clk); #1;
      bus.len    = (ADDR_W+1)'(1);
      bus.a_base = '0;
      @(negedge clk);
      chk("busy start_ready", int'(bus.start_ready), 0);
      wait_valid(seen, lat);
      chk("hold result_valid seen", int'(seen), 1);
      chk("hold latency", lat, vecs[3].lat + EXTRA);
      chk("hold result", int'($signed(bus.result)), exp3);
      stable = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.result_valid && int'($signed(bus.result)) == exp3 && !bus.start_ready)
            stable++;
      end
      chk("hold stable cycles", stable, 10);
      chk("hold rd_en count", rd_cnt, 3);
      chk("hold mac_clr count", clr_cnt, 1);
      bus.start_valid  = 1'b0;
      bus.result_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold start_ready after accept", int'(bus.start_ready), 1);
      chk("hold result_valid after accept", int'(bus.result_valid), 0);
      mon_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
